// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product in WIDTH
// RUN cycles, unsigned or two's-complement (via sign-magnitude) operation.
module seq_multiplier #(
    parameter int WIDTH = 3,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    // Handshake: start is sampled only in IDLE or DONE (ignored while busy, never
    // queued); busy is high for exactly the WIDTH RUN cycles; done pulses for one
    // cycle with p valid in that same cycle, and p holds until the next result.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   ZERO_W  = '0;
    localparam logic [2*WIDTH-1:0] ZERO_2W = '0;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_d;
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic                 last_iter;

    always_comb begin
        // Magnitude of 100..0 is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
        a_mag = a;
        b_mag = b;
        if (signed_mode && a[WIDTH-1]) a_mag = ZERO_W - a;
        if (signed_mode && b[WIDTH-1]) b_mag = ZERO_W - b;
        neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

        addend    = mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}};
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
        acc_d     = {sum, acc_q[WIDTH-1:1]};
        prod_d    = neg_q ? (ZERO_2W - acc_d) : acc_d;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= neg_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        p_q     <= prod_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign p    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=3 and WIDTH=8 instances, vector table
// plus hand-written back-to-back, ignore-while-busy and mid-run reset sequences.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start3 = 1'b0, sm3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic [5:0] p3;
    logic       busy3, done3;

    logic       start8 = 1'b0, sm8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic       busy8, done8;

    int tests = 0;
    int fails = 0;
    logic [15:0] last_exp [2];

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .signed_mode(sm3),
        .a(a3), .b(b3), .p(p3), .busy(busy3), .done(done3)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
    );

    typedef struct {
        bit          sel;     // 0 = WIDTH 3, 1 = WIDTH 8
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int cyc;
        int bcnt;
        int w;
        w = v.sel ? 8 : 3;
        @(posedge clk); #1;
        if (!v.sel) begin
            start3 = 1'b1; sm3 = v.sm; a3 = v.a[2:0]; b3 = v.b[2:0];
        end else begin
            start8 = 1'b1; sm8 = v.sm; a8 = v.a; b8 = v.b;
        end
        @(posedge clk); #1;
        start3 = 1'b0; start8 = 1'b0;
        // Operands wiggled after sampling must not matter.
        a3 = 3'd1; b3 = 3'd1; a8 = 8'd3; b8 = 8'd3;
        check({v.name, "_hold"}, v.sel ? p8 : {10'b0, p3}, last_exp[v.sel]);
        cyc = 0;
        bcnt = 0;
        while (!(v.sel ? done8 : done3) && cyc < 40) begin
            if (v.sel ? busy8 : busy3) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check({v.name, "_lat"}, cyc, w);
        check({v.name, "_busy"}, bcnt, w);
        check({v.name, "_p"}, v.sel ? p8 : {10'b0, p3}, v.exp);
        last_exp[v.sel] = v.exp;
        @(posedge clk); #1;
        check({v.name, "_pulse"}, v.sel ? done8 : done3, 1'b0);
    endtask

    vec_t vecs [$];
    int cyc;
    int ndone;
    int first_done;

    initial begin
        vecs.push_back('{0, 0, 8'd7, 8'd5, 16'd35, "u3_7x5"});
        vecs.push_back('{0, 0, 8'd6, 8'd5, 16'd30, "u3_6x5"});
        vecs.push_back('{0, 0, 8'd6, 8'd3, 16'd18, "u3_6x3"});
        vecs.push_back('{0, 0, 8'd5, 8'd5, 16'd25, "u3_5x5"});
        vecs.push_back('{0, 0, 8'd2, 8'd6, 16'd12, "u3_2x6"});
        vecs.push_back('{0, 1, 8'd7, 8'd5, 16'h0003, "s3_m1xm3"});
        vecs.push_back('{0, 1, 8'd6, 8'd3, 16'h003A, "s3_m2x3"});
        vecs.push_back('{0, 1, 8'd3, 8'd6, 16'h003A, "s3_3xm2"});
        vecs.push_back('{0, 1, 8'd4, 8'd4, 16'h0010, "s3_m4xm4"});
        vecs.push_back('{0, 1, 8'd0, 8'd5, 16'h0000, "s3_0xm3"});
        vecs.push_back('{0, 1, 8'd3, 8'd2, 16'h0006, "s3_3x2"});
        vecs.push_back('{1, 0, 8'hFF, 8'hFF, 16'd65025, "u8_255sq"});
        vecs.push_back('{1, 1, 8'h80, 8'h80, 16'h4000, "s8_minsq"});
        vecs.push_back('{1, 1, 8'h80, 8'h01, 16'hFF80, "s8_minx1"});
        vecs.push_back('{1, 1, 8'hFF, 8'h7F, 16'hFF81, "s8_m1x127"});
        vecs.push_back('{1, 0, 8'h00, 8'h00, 16'h0000, "u8_zero"});

        // Clock/reset
        last_exp[0] = '0;
        last_exp[1] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p3", p3, 6'd0);
        check("rst_busy3", busy3, 1'b0);
        check("rst_done3", done3, 1'b0);
        check("rst_p8", p8, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-to-back: start held high, next operands presented during DONE.
        @(posedge clk); #1;
        start3 = 1'b1; sm3 = 1'b0; a3 = 3'd7; b3 = 3'd5;
        @(posedge clk); #1;
        a3 = 3'd6; b3 = 3'd5;
        cyc = 0;
        while (!done3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_lat1", cyc, 3);
        check("b2b_p1", p3, 6'd35);
        cyc = 0;
        @(posedge clk); #1;
        cyc++;
        check("b2b_no_idle", busy3, 1'b1);
        while (!done3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_gap", cyc, 4);
        check("b2b_p2", p3, 6'd30);
        start3 = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_busy", busy3, 1'b0);
        check("b2b_end_done", done3, 1'b0);
        last_exp[0] = 16'd30;

        // Ignore-while-busy: second start lands at cycle 2 of the run.
        @(posedge clk); #1;
        start3 = 1'b1; a3 = 3'd7; b3 = 3'd5;
        @(posedge clk); #1;
        start3 = 1'b0; a3 = 3'd1; b3 = 3'd1;
        @(posedge clk); #1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        ndone = 0;
        first_done = -1;
        for (int i = 3; i < 14; i++) begin
            if (i > 3) begin
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
            if (done3) begin
                ndone++;
                if (first_done < 0) first_done = i;
            end
        end
        check("ign_ndone", ndone, 1);
        check("ign_lat", first_done, 3);
        check("ign_p", p3, 6'd35);
        last_exp[0] = 16'd35;

        // Reset during the second RUN cycle acts without a clock edge.
        @(posedge clk); #1;
        start3 = 1'b1; a3 = 3'd7; b3 = 3'd5;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_pre", busy3, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_p", p3, 6'd0);
        check("mid_rst_busy", busy3, 1'b0);
        check("mid_rst_done", done3, 1'b0);
        check("mid_rst_p8", p8, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        last_exp[0] = '0;
        last_exp[1] = '0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done3) ndone++;
        end
        check("mid_no_done", ndone, 0);
        run_op('{0, 0, 8'd2, 8'd6, 16'd12, "rst_recover"});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised, sequential shift-and-add multiplier. It is the successor to the fixed 3-bit combinational multiplier. It computes a WIDTH x WIDTH product over WIDTH clock cycles and supports unsigned and two's-complement signed modes. A start/busy/done handshake lets arithmetic datapaths and test sequencers issue back-to-back operations.

Parameters:
WIDTH, 3, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE or DONE.
signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned; sampled with start.
a  input  WIDTH  multiplicand; sampled with start.
b  input  WIDTH  multiplier; sampled with start.
p  output  2*WIDTH  product; registered; holds the last result until the next accepted start completes.
busy  output  1  high while the FSM is in RUN.
done  output  1  one-cycle pulse; p is valid in the same cycle.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, p=0, busy=0, done=0, counter=0, internal accumulator and operand registers=0. Reset takes effect immediately, including mid-RUN. The in-flight operation is discarded and no done is issued.
- FSM states are IDLE, RUN and DONE:
  - IDLE: on start=1, latch the operands, clear the accumulator and counter, and go to RUN. Otherwise stay in IDLE.
  - RUN: one iteration per cycle. If multiplier LSB=1, add the multiplicand to the upper half of the accumulator. Then shift right by 1 with carry-in, and increment the counter. After WIDTH iterations, go to DONE.
  - DONE: done=1 for exactly this cycle, and p updates on the edge entering DONE. If start=1 here, latch the new operands and go to RUN (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: start sampled at edge k. RUN occupies edges k+1..k+WIDTH. done=1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from start to done. Throughput is one result per WIDTH+1 cycles.
- busy=1 exactly during RUN. start while busy=1 is ignored; no queueing, no error flag.
- Operand changes after start is sampled have no effect on the current operation.
- Signed mode uses sign-magnitude:
  - Latch |a| and |b| as WIDTH-bit unsigned values. The magnitude of the most negative value (100..0) is 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  - Record sign = a[MSB] XOR b[MSB].
  - On entering DONE, p = sign ? two's-complement negation of the accumulator : accumulator.
  - The 2*WIDTH-bit result is always exact; (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits.
- Unsigned mode: p = a*b, exact in 2*WIDTH bits, no overflow possible.
- Zero operands still take the full WIDTH iterations (no early termination), so latency is constant.
- p is not cleared on start; it changes only on the edge entering DONE or on reset.

Test Plan:
- WIDTH=3, unsigned, single operations: (7,5) -> p=35 (6'b100011); (6,5) -> 30; (6,3) -> 18; (5,5) -> 25; (2,6) -> 12. For each, done is a single pulse exactly 4 cycles after start, and busy is high for 3 cycles.
- WIDTH=3, signed: a=3'b111, b=3'b101 (-1 x -3) -> p=6'b000011. a=3'b110, b=3'b011 (-2 x 3) -> p=6'b111010. a=b=3'b100 (-4 x -4) -> p=6'b010000. a=3'b000 x any -> p=0.
- Back-to-back: start held high continuously with new operands presented in each DONE cycle. Required: results 35, then 30, with done pulses 4 cycles apart and no IDLE cycle between them.
- Ignore-while-busy: start at cycle 0 with (7,5), then start with (1,1) at cycle 2. Required: only one done, p=35; the second request is dropped.
- Reset mid-operation: assert rst during the 2nd RUN cycle. Required: p=0, busy=0, done=0 immediately, without waiting for a clock edge. After release, start (2,6) -> p=12 with normal latency.
- WIDTH=8: unsigned (255,255) -> p=65025. Signed (8'h80, 8'h80) -> p=16'h4000. Signed (8'h80, 8'h01) -> p=16'hFF80. done appears 9 cycles after start.
